mac_tile_mp: RTL and testbench

- Parametrised, weight-stationary, multi-precision successor to the 2-lane systolic MAC tile.
- Holds LANES weight/activation lanes built from 2-bit-activation × 4-bit-weight mac cells.
- Runs in 2-, 4- or 8-bit activation mode by fusing groups of lanes with shift-add.
- Sits in the systolic array: activations pass east, weights/instructions pass east after local capture, partial sums flow north to south.

---
 rtl/mac_tile_mp_pkg.sv | 32 +++
 rtl/mac_tile_mp_if.sv | 29 ++
 rtl/mac_tile_mp_cell.sv | 18 +
 rtl/mac_tile_mp.sv | 107 ++++++++++
 tb/tb_mac_tile_mp.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/mac_tile_mp_pkg.sv
// Shared encodings and lane-grouping helpers for the multi-precision MAC tile.
package mac_mp_pkg;

    typedef enum logic [1:0] {
        MODE_2B = 2'b00,
        MODE_4B = 2'b01,
        MODE_8B = 2'b10
    } mode_e;

    typedef enum logic {
        WAIT_LOAD = 1'b0,
        LOADED    = 1'b1
    } state_e;

    // Reserved encoding 11 falls back to the 2-bit grouping.
    function automatic int group_size(input logic [1:0] mode);
        case (mode)
            MODE_4B: return 2;
            MODE_8B: return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int lane_src(input logic [1:0] mode, input int lane);
        return lane & ~(group_size(mode) - 1);
    endfunction

    function automatic int lane_shift(input logic [1:0] mode, input int lane, input int a_bw);
        return a_bw * (lane & (group_size(mode) - 1));
    endfunction

endpackage

// File: rtl/mac_tile_mp_if.sv
// Systolic-neighbour bus of the MAC tile: west/north inputs, east/south outputs.
interface mac_tile_mp_if #(
    parameter int LANES   = 4,
    parameter int a_bw    = 2,
    parameter int w_bw    = 4,
    parameter int psum_bw = 16
);
    logic [1:0]              mode;
    logic                    reload;
    logic [1:0]              inst_w;
    logic [1:0]              inst_e;
    logic [LANES*a_bw-1:0]   in_x;
    logic [LANES*a_bw-1:0]   out_x;
    logic [LANES*w_bw-1:0]   in_w;
    logic [LANES*w_bw-1:0]   out_w;
    logic [psum_bw-1:0]      in_psum_c;
    logic [psum_bw-1:0]      out_s;
    logic                    loaded;

    modport master (
        output mode, reload, inst_w, in_x, in_w, in_psum_c,
        input  inst_e, out_x, out_w, out_s, loaded
    );

    modport slave (
        input  mode, reload, inst_w, in_x, in_w, in_psum_c,
        output inst_e, out_x, out_w, out_s, loaded
    );
endinterface

// File: rtl/mac_tile_mp_cell.sv
// Base MAC cell: unsigned activation times signed weight plus carry-in.
module mac_tile_mp_cell #(
    parameter int a_bw    = 2,
    parameter int w_bw    = 4,
    parameter int psum_bw = 16
) (
    input  logic        [a_bw-1:0]    i_a,
    input  logic signed [w_bw-1:0]    i_b,
    input  logic signed [psum_bw-1:0] i_c,
    output logic signed [psum_bw-1:0] o_out
);
    logic signed [psum_bw-1:0] w_a;
    logic signed [psum_bw-1:0] w_b;

    assign w_a   = psum_bw'(i_a);
    assign w_b   = psum_bw'(i_b);
    assign o_out = w_a * w_b + i_c;
endmodule

// File: rtl/mac_tile_mp.sv
// Weight-stationary multi-precision MAC tile: lanes fused in groups of 1/2/4 by shift-add.
module mac_tile_mp
    import mac_mp_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int a_bw    = 2,
    parameter int w_bw    = 4,
    parameter int psum_bw = 16
) (
    input  logic          clk,
    input  logic          reset,
    mac_tile_mp_if.slave  bus
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    state_e                        r_state, w_state_nxt;
    logic [1:0]                    r_mode;
    logic [LANES-1:0][w_bw-1:0]    r_b;
    logic [LANES-1:0][a_bw-1:0]    r_a;
    logic [psum_bw-1:0]            r_c;
    logic [1:0]                    r_inst_e;
    logic [LANES*w_bw-1:0]         r_out_w;

    logic [LANES-1:0][w_bw-1:0]    w_in_w;
    logic [LANES-1:0][w_bw-1:0]    w_b_cap;
    logic signed [psum_bw-1:0]     w_p [LANES];
    logic [psum_bw-1:0]            w_sum;
    logic                          w_capture;
    logic                          w_pass;

    assign w_in_w = bus.in_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= WAIT_LOAD;
        else       r_state <= w_state_nxt;
    end

    // reload wins over a simultaneous kernel load, so no capture that cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_pass      = 1'b0;
        if (bus.reload) begin
            w_state_nxt = WAIT_LOAD;
        end else begin
            case (r_state)
                WAIT_LOAD: if (bus.inst_w[0]) begin
                    w_capture   = 1'b1;
                    w_state_nxt = LOADED;
                end
                LOADED:    w_pass = bus.inst_w[0];
                default:   w_state_nxt = WAIT_LOAD;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            // Every lane of a fused group takes the weight of the group's first lane.
            assign w_b_cap[gi] = w_in_w[LW'(lane_src(bus.mode, gi))];

            mac_tile_mp_cell #(
                .a_bw    (a_bw),
                .w_bw    (w_bw),
                .psum_bw (psum_bw)
            ) u_cell (
                .i_a   (r_a[gi]),
                .i_b   (r_b[gi]),
                .i_c   ('0),
                .o_out (w_p[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode   <= '0;
            r_b      <= '0;
            r_a      <= '0;
            r_c      <= '0;
            r_inst_e <= '0;
            r_out_w  <= '0;
        end else begin
            r_c      <= bus.in_psum_c;
            r_inst_e <= {bus.inst_w[1], w_pass};
            if (bus.inst_w[1]) r_a <= bus.in_x;
            if (w_capture) begin
                r_b    <= w_b_cap;
                r_mode <= bus.mode;
            end
            if (w_pass) r_out_w <= bus.in_w;
        end
    end

    // Lane k within a group carries activation bits [2k+1:2k], hence the shift.
    always_comb begin
        w_sum = r_c;
        for (int i = 0; i < LANES; i++)
            w_sum = w_sum + (w_p[i] << lane_shift(r_mode, i, a_bw));
    end

    assign bus.out_s  = w_sum;
    assign bus.out_x  = r_a;
    assign bus.out_w  = r_out_w;
    assign bus.inst_e = r_inst_e;
    assign bus.loaded = (r_state == LOADED);
endmodule

// File: tb/tb_mac_tile_mp.sv
// Scoreboard bench for mac_tile_mp: model predicts each cycle's outputs, monitor compares.
module tb_mac_tile_mp;
    localparam int LANES = 4, A_BW = 2, W_BW = 4, PSUM_BW = 16;

    typedef struct packed {
        logic [1:0]            inst_e;
        logic [LANES*A_BW-1:0] out_x;
        logic [LANES*W_BW-1:0] out_w;
        logic [PSUM_BW-1:0]    out_s;
        logic                  loaded;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mac_tile_mp_if #(.LANES(LANES), .a_bw(A_BW), .w_bw(W_BW), .psum_bw(PSUM_BW)) bus();

    mac_tile_mp #(.LANES(LANES), .a_bw(A_BW), .w_bw(W_BW), .psum_bw(PSUM_BW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t q[$];
    event mon_ev;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state
    bit                    m_loaded;
    int                    m_w[LANES];
    int                    m_g;
    logic [LANES*A_BW-1:0] m_a;
    logic [PSUM_BW-1:0]    m_c;
    logic [1:0]            m_ie;
    logic [LANES*W_BW-1:0] m_ow;

    function automatic int gsize(input logic [1:0] md);
        if (md == 2'b01) return 2;
        if (md == 2'b10) return 4;
        return 1;
    endfunction

    task automatic model_reset();
        m_loaded = 0; m_g = 1; m_a = '0; m_c = '0; m_ie = '0; m_ow = '0;
        for (int i = 0; i < LANES; i++) m_w[i] = 0;
    endtask

    task automatic model_step();
        logic signed [W_BW-1:0] s;
        m_c     = bus.in_psum_c;
        m_ie[1] = bus.inst_w[1];
        if (bus.inst_w[1]) m_a = bus.in_x;
        if (bus.reload) begin
            m_loaded = 0; m_ie[0] = 1'b0;
        end else if (!m_loaded) begin
            m_ie[0] = 1'b0;
            if (bus.inst_w[0]) begin
                for (int i = 0; i < LANES; i++) begin
                    s = bus.in_w[i*W_BW +: W_BW];
                    m_w[i] = int'(s);
                end
                m_g = gsize(bus.mode);
                m_loaded = 1;
            end
        end else begin
            m_ie[0] = bus.inst_w[0];
            if (bus.inst_w[0]) m_ow = bus.in_w;
        end
    endtask

    // Each group acts as one wide unsigned activation times its first-lane weight.
    function automatic exp_t model_out();
        exp_t e;
        longint acc, act;
        logic signed [PSUM_BW-1:0] cs;
        cs  = m_c;
        acc = longint'(cs);
        for (int g0 = 0; g0 < LANES; g0 += m_g) begin
            act = 0;
            for (int j = 0; j < m_g; j++)
                act += longint'(m_a[(g0+j)*A_BW +: A_BW]) << (A_BW*j);
            acc += act * m_w[g0];
        end
        e.inst_e = m_ie;
        e.out_x  = m_a;
        e.out_w  = m_ow;
        e.out_s  = acc[PSUM_BW-1:0];
        e.loaded = m_loaded;
        return e;
    endfunction

    task automatic check(input exp_t e);
        vectors++;
        if (bus.inst_e !== e.inst_e || bus.out_x !== e.out_x || bus.out_w !== e.out_w ||
            bus.out_s !== e.out_s || bus.loaded !== e.loaded) begin
            miscompares++;
            $display("FAIL vec %0d @%0t: inst_e %b/%b out_x %h/%h out_w %h/%h out_s %h/%h loaded %b/%b (got/exp)",
                     vectors, $time, bus.inst_e, e.inst_e, bus.out_x, e.out_x, bus.out_w, e.out_w,
                     bus.out_s, e.out_s, bus.loaded, e.loaded);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk or mon_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                check(e);
            end
        end
    end

    task automatic step(input logic [1:0] inst, input logic rl, input logic [1:0] md,
                        input logic [15:0] w, input logic [7:0] x, input logic [15:0] ps);
        bus.inst_w = inst; bus.reload = rl; bus.mode = md;
        bus.in_w = w; bus.in_x = x; bus.in_psum_c = ps;
        @(posedge clk);
        model_step();
        q.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic async_reset_check();
        #2 reset = 1'b1;
        #1;
        model_reset();
        q.push_back(model_out());
        ->mon_ev;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : driver
        bus.inst_w = '0; bus.reload = 1'b0; bus.mode = '0;
        bus.in_w = '0; bus.in_x = '0; bus.in_psum_c = '0;
        model_reset();
        #2;
        q.push_back(model_out());
        ->mon_ev;
        @(negedge clk);
        reset = 1'b0;

        // 2-bit: w = {3,-2,1,7}, a = {1,2,3,0}, psum 10 -> 12
        step(2'b01, 0, 2'b00, 16'h71E3, 8'h00, 16'd0);
        step(2'b10, 0, 2'b00, 16'h0000, 8'h39, 16'd10);
        step(2'b00, 0, 2'b00, 16'h0000, 8'h00, 16'd0);
        // 4-bit: w = {3,x,-1,x}, a = {1,2,3,1} -> 20
        step(2'b00, 1, 2'b00, 16'h0000, 8'h00, 16'd0);
        step(2'b01, 0, 2'b01, 16'h9F53, 8'h00, 16'd0);
        step(2'b10, 0, 2'b11, 16'h0000, 8'h79, 16'd0);
        step(2'b00, 0, 2'b00, 16'h0000, 8'h00, 16'd0);
        // 8-bit: w0 = -8, a = 255, psum 100 -> -1940
        step(2'b00, 1, 2'b00, 16'h0000, 8'h00, 16'd0);
        step(2'b01, 0, 2'b10, 16'hABC8, 8'h00, 16'd0);
        step(2'b10, 0, 2'b00, 16'h0000, 8'hFF, 16'd100);
        step(2'b00, 0, 2'b00, 16'h0000, 8'h00, 16'd0);
        // Load chain A, B, C
        step(2'b00, 1, 2'b00, 16'h0000, 8'h00, 16'd0);
        step(2'b01, 0, 2'b00, 16'h1111, 8'h00, 16'd0);
        step(2'b01, 0, 2'b00, 16'h2222, 8'h00, 16'd0);
        step(2'b01, 0, 2'b00, 16'h3333, 8'h00, 16'd0);
        step(2'b10, 0, 2'b00, 16'h0000, 8'hE4, 16'd7);
        step(2'b00, 0, 2'b00, 16'h0000, 8'h00, 16'd0);
        // Reload colliding with load, then D captured in 4-bit mode
        step(2'b01, 1, 2'b10, 16'h8888, 8'h00, 16'd0);
        step(2'b01, 0, 2'b01, 16'h4C5A, 8'h00, 16'd0);
        step(2'b11, 0, 2'b10, 16'h7777, 8'hB6, 16'hFFF0);
        step(2'b00, 0, 2'b00, 16'h0000, 8'h00, 16'd0);
        // Mid-operation async reset, then a fresh load is captured
        step(2'b10, 0, 2'b00, 16'h0000, 8'h5A, 16'd3);
        async_reset_check();
        step(2'b01, 0, 2'b00, 16'h3D2E, 8'h00, 16'd0);
        step(2'b10, 0, 2'b00, 16'h0000, 8'hC3, 16'd50);
        step(2'b00, 0, 2'b00, 16'h0000, 8'h00, 16'd0);

        for (int n = 0; n < 400; n++)
            step(2'($urandom), ($urandom_range(0, 15) == 0), 2'($urandom),
                 16'($urandom), 8'($urandom), 16'($urandom));

        @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard drain: %0d entries left, 0 required", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
